// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_wr_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          done_o,
    output logic [DATA_W-1:0]           rdata_o,
    output logic                        err_o,
    output logic                        busy_o,
    output logic [1:0]                  state_o,
    output logic [ADDR_W-1:0]           PADDR,
    output logic                        PSELx,
    output logic                        PENABLE,
    output logic                        PWRITE,
    output logic [DATA_W-1:0]           PWDATA,
    input  logic                        PREADY,
    input  logic [DATA_W-1:0]           PRDATA,
    input  logic                        PSLVERR
);
    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb_req_arbiter: unsupported parameter value");
    end

    // Handshake: a requester holds req_i with stable command fields until its
    // done_o pulse; the APB side follows SETUP -> ACCESS, completing on PREADY.
    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, mask_q, mask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, pwdata_q, pwdata_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                err_q, err_d, busy_q, busy_d;
    logic                psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;

    logic [NUM_REQ-1:0]  req_m, gnt_win;
    logic [PTR_W-1:0]    idx, win_idx;
    logic                win_found, grant_now, complete, timeout_hit;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_wr;

    // The completing owner is ignored in its completion cycle and the one after.
    assign req_m = req_i & ~mask_q & ((state_q == ACCESS) ? ~gnt_q : {NUM_REQ{1'b1}});

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req_m[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
        gnt_win          = '0;
        gnt_win[win_idx] = 1'b1;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wr    = 1'b0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                sel_wr    = req_wr_i[k];
                sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    // Terminates on the wait cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == ACCESS) && !PREADY &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ACCESS && !PREADY) tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (state_d == SETUP) tmo_cnt_d = '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) tmo_cnt_q <= '0;
        else          tmo_cnt_q <= tmo_cnt_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        mask_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        busy_d    = busy_q;
        paddr_d   = paddr_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        grant_now = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                busy_d    = 1'b0;
                grant_now = win_found;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                complete = PREADY | timeout_hit;
                if (complete) begin
                    done_d    = gnt_q;
                    mask_d    = gnt_q;
                    err_d     = PREADY ? PSLVERR : 1'b1;
                    if (PREADY && !pwrite_q) rdata_d = PRDATA;
                    gnt_d     = '0;
                    penable_d = 1'b0;
                    if (win_found) begin
                        grant_now = 1'b1;
                    end else begin
                        state_d = IDLE;
                        psel_d  = 1'b0;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_now) begin
            state_d   = SETUP;
            ptr_d     = win_idx;
            gnt_d     = gnt_win;
            paddr_d   = sel_addr;
            pwrite_d  = sel_wr;
            pwdata_d  = sel_wdata;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            busy_d    = 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            gnt_q     <= '0;
            done_q    <= '0;
            mask_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            mask_q    <= mask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            paddr_q   <= paddr_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign state_o = state_q;
    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign busy_o  = busy_q;
    assign PADDR   = paddr_q;
    assign PSELx   = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;

endmodule
